// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/stall controller: stage indices,
// long-latency tracker state encoding and default channel ids.
package hazard_pkg;

    // Pipeline stage indices into the stall/bubble vectors.
    localparam int NUM_STAGES = 5;
    localparam int STG_IF     = 0;
    localparam int STG_ID     = 1;
    localparam int STG_EX     = 2;
    localparam int STG_MEM    = 3;
    localparam int STG_WB     = 4;

    // Long-latency tracker states.
    typedef enum logic [1:0] {
        TRK_IDLE  = 2'd0,
        TRK_WAIT  = 2'd1,
        TRK_ABORT = 2'd2
    } trk_state_e;

    // Default channel assignment of the long-latency request bus.
    localparam int CH_CACHE = 0;
    localparam int CH_BUS   = 1;
    localparam int CH_ACC   = 2;

endpackage

// File: rtl/long_op_tracker.sv
// Multi-channel long-latency operation tracker. Collects outstanding
// channels into a pending mask, waits for their completion pulses and
// aborts with a sticky error flag once the wait exceeds TIMEOUT_CYC.
module long_op_tracker
    import hazard_pkg::*;
#(
    parameter int NUM_LONG_CH = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_LONG_CH-1:0] long_req,
    input  logic [NUM_LONG_CH-1:0] long_done,
    output logic                   long_stall,
    output logic [NUM_LONG_CH-1:0] pending,
    output logic                   timeout_err,
    output trk_state_e             state_o
);

    // Last WAIT count value before the abort fires.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

    trk_state_e             state_q, state_d;
    logic [NUM_LONG_CH-1:0] pending_q, pending_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   terr_q, terr_d;
    logic [NUM_LONG_CH-1:0] req_live;
    logic [NUM_LONG_CH-1:0] wait_left;

    // A request whose done pulse arrives in the same cycle is already complete.
    assign req_live  = long_req & ~long_done;
    assign wait_left = pending_q & ~long_done;

    // State, pending mask, wait counter and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TRK_IDLE;
            pending_q <= '0;
            cnt_q     <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            terr_q    <= terr_d;
        end
    end

    // Next-state and register update: requests are only sampled in IDLE.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        terr_d    = terr_q;
        case (state_q)
            TRK_IDLE: begin
                if (|long_req) begin
                    pending_d = req_live;
                    cnt_d     = '0;
                end
                if (|req_live) begin
                    state_d = TRK_WAIT;
                end
            end
            TRK_WAIT: begin
                pending_d = wait_left;
                cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                if (!(|wait_left)) begin
                    state_d = TRK_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = TRK_ABORT;
                end
            end
            TRK_ABORT: begin
                pending_d = '0;
                terr_d    = 1'b1;
                state_d   = TRK_IDLE;
            end
            default: begin
                state_d = TRK_IDLE;
            end
        endcase
    end

    // Outputs: stall covers the request cycle and the completion cycle.
    always_comb begin
        long_stall  = ((state_q == TRK_IDLE) && (|req_live)) ||
                      (state_q == TRK_WAIT) || (state_q == TRK_ABORT);
        pending     = pending_q;
        timeout_err = terr_q;
        state_o     = state_q;
    end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard/stall controller for the 5-stage RV32 core. Combines branch/jalr
// operand hazards, load-use hazards, control redirects and the long-latency
// tracker into per-stage stall and bubble vectors.
// Optional macro HAZARD_PERF_CNT_EN adds three free-running perf counters.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int NUM_LONG_CH = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_branch,
    input  logic                   id_jalr,
    input  logic                   id_jal,
    input  logic [REG_AW-1:0]      id_rs1,
    input  logic [REG_AW-1:0]      id_rs2,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic                   id_redirect,
    input  logic [REG_AW-1:0]      ex_rd,
    input  logic                   ex_reg_write,
    input  logic                   ex_mem_read,
    input  logic [REG_AW-1:0]      mem_rd,
    input  logic                   mem_mem_read,
    input  logic [NUM_LONG_CH-1:0] long_req,
    input  logic [NUM_LONG_CH-1:0] long_done,
    output logic [NUM_STAGES-1:0]  stall,
    output logic [NUM_STAGES-1:0]  bubble,
    output logic                   long_busy,
    output logic [NUM_LONG_CH-1:0] pending,
    output logic                   timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]            perf_data_stall_cyc,
    output logic [31:0]            perf_long_stall_cyc,
    output logic [31:0]            perf_flush_cnt
`endif
);

    logic       long_stall;
    logic       data_stall;
    logic       rs1_ex, rs2_ex, rs1_mem, rs2_mem;
    logic       br_use;
    trk_state_e trk_state;

    long_op_tracker #(
        .NUM_LONG_CH (NUM_LONG_CH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .long_req    (long_req),
        .long_done   (long_done),
        .long_stall  (long_stall),
        .pending     (pending),
        .timeout_err (timeout_err),
        .state_o     (trk_state)
    );

    // Operand matching (x0 never matches) and the data hazard condition.
    always_comb begin
        rs1_ex  = id_rs1_used && (id_rs1 != '0) && (id_rs1 == ex_rd);
        rs2_ex  = id_rs2_used && (id_rs2 != '0) && (id_rs2 == ex_rd);
        rs1_mem = id_rs1_used && (id_rs1 != '0) && (id_rs1 == mem_rd);
        rs2_mem = id_rs2_used && (id_rs2 != '0) && (id_rs2 == mem_rd);
        br_use  = id_branch || id_jalr;
        data_stall = (br_use && ex_reg_write && (rs1_ex || rs2_ex)) ||
                     (br_use && mem_mem_read && (rs1_mem || rs2_mem)) ||
                     (ex_mem_read && (rs1_ex || rs2_ex));
    end

    // Stage stall/bubble muxing; a long stall freezes everything and
    // suppresses every bubble so the held instruction survives.
    always_comb begin
        stall     = '0;
        bubble    = '0;
        long_busy = (trk_state != TRK_IDLE);
        if (!rst_n) begin
            bubble = '1;
        end else begin
            stall[STG_IF]  = long_stall || data_stall;
            stall[STG_ID]  = long_stall || data_stall;
            stall[STG_EX]  = long_stall;
            stall[STG_MEM] = long_stall;
            stall[STG_WB]  = long_stall;
            bubble[STG_ID] = !long_stall && !data_stall && (id_redirect || id_jal);
            bubble[STG_EX] = !long_stall && data_stall;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_data_q, perf_data_d;
    logic [31:0] perf_long_q, perf_long_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Wrapping event counters for stall and flush cycles.
    always_comb begin
        perf_data_d  = perf_data_q  + {31'd0, (data_stall && !long_stall)};
        perf_long_d  = perf_long_q  + {31'd0, long_stall};
        perf_flush_d = perf_flush_q + {31'd0, bubble[STG_ID]};
    end

    // Perf counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_data_q  <= '0;
            perf_long_q  <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_data_q  <= perf_data_d;
            perf_long_q  <= perf_long_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_data_stall_cyc = perf_data_q;
    assign perf_long_stall_cyc = perf_long_q;
    assign perf_flush_cnt      = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: directed vectors with hand-computed responses.
// A second instance with TIMEOUT_CYC=4 exercises the abort path.
module tb_hazard_ctrl_mc;

    typedef struct {
        int         id;
        logic       sel;
        logic [4:0] stall;
        logic [4:0] bubble;
        logic [2:0] pend;
        logic       busy;
        logic       terr;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       id_branch, id_jalr, id_jal;
    logic [4:0] id_rs1, id_rs2;
    logic       id_rs1_used, id_rs2_used, id_redirect;
    logic [4:0] ex_rd;
    logic       ex_reg_write, ex_mem_read;
    logic [4:0] mem_rd;
    logic       mem_mem_read;
    logic [2:0] long_req, long_done, long_req_to, long_done_to;

    logic [4:0] stall, bubble, stall_to, bubble_to;
    logic       long_busy, long_busy_to, timeout_err, timeout_err_to;
    logic [2:0] pending, pending_to;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_d, perf_l, perf_f, perf_d_to, perf_l_to, perf_f_to;
`endif

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    int   vec_id;

    hazard_ctrl_mc dut (
        .clk(clk), .rst_n(rst_n),
        .id_branch(id_branch), .id_jalr(id_jalr), .id_jal(id_jal),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_redirect(id_redirect),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
        .long_req(long_req), .long_done(long_done),
        .stall(stall), .bubble(bubble), .long_busy(long_busy),
        .pending(pending), .timeout_err(timeout_err)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_data_stall_cyc(perf_d), .perf_long_stall_cyc(perf_l),
        .perf_flush_cnt(perf_f)
`endif
    );

    hazard_ctrl_mc #(.TIMEOUT_CYC(4)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .id_branch(id_branch), .id_jalr(id_jalr), .id_jal(id_jal),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_redirect(id_redirect),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
        .long_req(long_req_to), .long_done(long_done_to),
        .stall(stall_to), .bubble(bubble_to), .long_busy(long_busy_to),
        .pending(pending_to), .timeout_err(timeout_err_to)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_data_stall_cyc(perf_d_to), .perf_long_stall_cyc(perf_l_to),
        .perf_flush_cnt(perf_f_to)
`endif
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_branch = 0; id_jalr = 0; id_jal = 0;
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_redirect = 0;
        ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        mem_rd = 0; mem_mem_read = 0;
        long_req = 0; long_done = 0; long_req_to = 0; long_done_to = 0;
    endtask

    task automatic expect_v(input logic sel, input logic [4:0] st,
                            input logic [4:0] bu, input logic [2:0] pe,
                            input logic bz, input logic te);
        exp_t e;
        e.id = vec_id; e.sel = sel; e.stall = st; e.bubble = bu;
        e.pend = pe; e.busy = bz; e.terr = te;
        exp_q.push_back(e);
        vec_id++;
    endtask

    // Scoreboard monitor: checks one expected response per cycle mid-cycle.
    initial begin
        exp_t e;
        logic [4:0] a_st, a_bu;
        logic [2:0] a_pe;
        logic       a_bz, a_te;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.sel) begin
                    a_st = stall_to; a_bu = bubble_to; a_pe = pending_to;
                    a_bz = long_busy_to; a_te = timeout_err_to;
                end else begin
                    a_st = stall; a_bu = bubble; a_pe = pending;
                    a_bz = long_busy; a_te = timeout_err;
                end
                n_vec++;
                if ({a_st, a_bu, a_pe, a_bz, a_te} !==
                    {e.stall, e.bubble, e.pend, e.busy, e.terr}) begin
                    n_err++;
                    $display("FAIL vec%0d(dut%0d): got stall=%b bubble=%b pending=%b busy=%b terr=%b, want stall=%b bubble=%b pending=%b busy=%b terr=%b",
                             e.id, e.sel, a_st, a_bu, a_pe, a_bz, a_te,
                             e.stall, e.bubble, e.pend, e.busy, e.terr);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        int guard;
        n_vec = 0; n_err = 0; vec_id = 0;
        clear_inputs();
        rst_n = 1'b0;

        // Reset state on both instances
        next_cycle(); expect_v(0, 5'b00000, 5'b11111, 3'b000, 0, 0);
        next_cycle(); expect_v(1, 5'b00000, 5'b11111, 3'b000, 0, 0);
        next_cycle(); rst_n = 1'b1; expect_v(0, 5'b00000, 5'b00000, 3'b000, 0, 0);

        // Load-use on rs1
        next_cycle(); clear_inputs();
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
        expect_v(0, 5'b00011, 5'b00100, 3'b000, 0, 0);
        // x0 never matches
        next_cycle(); id_rs1 = 0; ex_rd = 0;
        expect_v(0, 5'b00000, 5'b00000, 3'b000, 0, 0);
        // Matching rs2 that is not read
        next_cycle(); ex_rd = 5; id_rs2 = 5; id_rs2_used = 0;
        expect_v(0, 5'b00000, 5'b00000, 3'b000, 0, 0);

        // Branch after ALU with a simultaneous redirect: stall wins
        next_cycle(); clear_inputs();
        id_branch = 1; id_rs2 = 7; id_rs2_used = 1; ex_reg_write = 1; ex_rd = 7;
        id_redirect = 1;
        expect_v(0, 5'b00011, 5'b00100, 3'b000, 0, 0);
        // Hazard cleared, redirect now flushes ID
        next_cycle(); ex_reg_write = 0; ex_rd = 0;
        expect_v(0, 5'b00000, 5'b00010, 3'b000, 0, 0);
        // jalr against a load in MEM
        next_cycle(); clear_inputs();
        id_jalr = 1; id_rs1 = 9; id_rs1_used = 1; mem_mem_read = 1; mem_rd = 9;
        expect_v(0, 5'b00011, 5'b00100, 3'b000, 0, 0);
        // jal alone flushes ID
        next_cycle(); clear_inputs(); id_jal = 1;
        expect_v(0, 5'b00000, 5'b00010, 3'b000, 0, 0);
        // ALU producer feeding a non-branch consumer is forwarded, no stall
        next_cycle(); clear_inputs();
        ex_reg_write = 1; ex_rd = 3; id_rs1 = 3; id_rs1_used = 1;
        expect_v(0, 5'b00000, 5'b00000, 3'b000, 0, 0);

        // Two-channel miss; the redirect in the request cycle is suppressed
        next_cycle(); clear_inputs(); long_req = 3'b011; id_redirect = 1;
        expect_v(0, 5'b11111, 5'b00000, 3'b000, 0, 0);
        next_cycle(); clear_inputs(); expect_v(0, 5'b11111, 5'b00000, 3'b011, 1, 0);
        next_cycle(); expect_v(0, 5'b11111, 5'b00000, 3'b011, 1, 0);
        next_cycle(); long_done = 3'b001;
        expect_v(0, 5'b11111, 5'b00000, 3'b011, 1, 0);
        next_cycle(); clear_inputs(); expect_v(0, 5'b11111, 5'b00000, 3'b010, 1, 0);
        next_cycle(); expect_v(0, 5'b11111, 5'b00000, 3'b010, 1, 0);
        next_cycle(); long_done = 3'b010;
        expect_v(0, 5'b11111, 5'b00000, 3'b010, 1, 0);
        next_cycle(); clear_inputs(); expect_v(0, 5'b00000, 5'b00000, 3'b000, 0, 0);

        // Same-cycle request and done: already complete
        next_cycle(); long_req = 3'b100; long_done = 3'b100;
        expect_v(0, 5'b00000, 5'b00000, 3'b000, 0, 0);
        next_cycle(); clear_inputs(); expect_v(0, 5'b00000, 5'b00000, 3'b000, 0, 0);

        // Timeout on the TIMEOUT_CYC=4 instance
        next_cycle(); long_req_to = 3'b001;
        expect_v(1, 5'b11111, 5'b00000, 3'b000, 0, 0);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); clear_inputs();
            expect_v(1, 5'b11111, 5'b00000, 3'b001, 1, 0);
        end
        next_cycle(); expect_v(1, 5'b11111, 5'b00000, 3'b001, 1, 0);
        next_cycle(); expect_v(1, 5'b00000, 5'b00000, 3'b000, 0, 1);
        next_cycle(); expect_v(1, 5'b00000, 5'b00000, 3'b000, 0, 1);

        // Asynchronous reset in the middle of a WAIT
        next_cycle(); long_req = 3'b001;
        expect_v(0, 5'b11111, 5'b00000, 3'b000, 0, 0);
        next_cycle(); clear_inputs(); expect_v(0, 5'b11111, 5'b00000, 3'b001, 1, 0);
        next_cycle(); rst_n = 1'b0;
        expect_v(0, 5'b00000, 5'b11111, 3'b000, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
        #1;
        n_vec++;
        if ({perf_d, perf_l, perf_f} !== 96'd0) begin
            n_err++;
            $display("FAIL perf_reset: got %0d/%0d/%0d, want 0/0/0", perf_d, perf_l, perf_f);
        end
`endif
        next_cycle(); expect_v(1, 5'b00000, 5'b11111, 3'b000, 0, 0);
        next_cycle(); rst_n = 1'b1; expect_v(0, 5'b00000, 5'b00000, 3'b000, 0, 0);

        // Drain the scoreboard with a bounded wait
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            next_cycle();
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Next-generation hazard/stall controller for the 5-stage RV32 core: IF, ID, EX, MEM, WB.
- Detects branch/jalr operand hazards, load-use hazards and control redirects, as before.
- Adds a sequential multi-channel long-latency tracker with a timeout. The channels are cache miss, data bus and accelerator.
- Emits per-stage stall and bubble vectors consumed by the pipeline registers.

Parameters:
- REG_AW, 5: register address width.
- NUM_LONG_CH, 3: number of long-latency request channels. Channel 0 is cache, 1 is bus, 2 is accelerator.
- TIMEOUT_CYC, 255: maximum WAIT cycles before abort. Range 1..2^16-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_branch, id_jalr, id_jal  in  1 each  instruction class in ID.
- id_rs1, id_rs2  in  REG_AW  ID source registers.
- id_rs1_used, id_rs2_used  in  1 each  source is actually read.
- id_redirect  in  1  ID resolved a taken branch/jal/jalr this cycle.
- ex_rd  in  REG_AW;  ex_reg_write, ex_mem_read  in  1 each.
- mem_rd  in  REG_AW;  mem_mem_read  in  1.
- long_req  in  NUM_LONG_CH  a MEM-stage instruction starts a long operation on channel i. Level, sampled in IDLE only.
- long_done  in  NUM_LONG_CH  single-cycle completion pulse per channel.
- stall  out  5  per-stage hold, index order IF, ID, EX, MEM, WB.
- bubble  out  5  per-stage flush to NOP, same index order.
- long_busy  out  1  tracker not IDLE.
- pending  out  NUM_LONG_CH  outstanding-channel mask.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset:
  - rst_n low asynchronously forces state IDLE, pending=0, wait counter=0, timeout_err=0.
  - While rst_n is low: stall=0 and bubble=5'b11111, combinationally.
  - The first edge after release sees normal operation.
- Match rule: a source matches only if its *_used flag is 1 and the register is nonzero. x0 never matches.
- data_stall (combinational), asserted on any of:
  - (id_branch|id_jalr) & ex_reg_write & rs matches ex_rd.
  - (id_branch|id_jalr) & mem_mem_read & rs matches mem_rd.
  - ex_mem_read & rs matches ex_rd (load-use).
- Tracker FSM, states IDLE / WAIT / ABORT:
  - IDLE: if |long_req, then pending <= long_req & ~long_done, counter <= 0. Go to WAIT if the new pending is nonzero, else stay in IDLE.
  - WAIT: pending <= pending & ~long_done, counter++. Return to IDLE when the next pending is 0. Go to ABORT when counter == TIMEOUT_CYC-1 and pending is still nonzero.
  - ABORT: one cycle. pending <= 0, timeout_err <= 1. Next state IDLE.
  - long_done on a channel not pending is ignored.
  - long_req is ignored outside IDLE.
- long_stall = (IDLE & |(long_req & ~long_done)) | WAIT | ABORT.
  - Combinational, so the stall appears in the same cycle as the request.
  - The cycle in which the last done arrives is still stalled; release is on the next cycle.
- Outputs:
  - stall[IF], stall[ID] = long_stall | data_stall.
  - stall[EX], stall[MEM], stall[WB] = long_stall.
  - bubble[ID] = ~long_stall & ~data_stall & (id_redirect | id_jal).
  - bubble[EX] = ~long_stall & data_stall.
  - bubble[IF], bubble[MEM], bubble[WB] = 0, except during reset.
  - long_stall suppresses all bubbles: the frozen pipeline must not lose the held instruction.
- Simultaneous events:
  - data_stall together with id_redirect: the stall wins, and the redirect is re-evaluated next cycle.
  - long_done and long_req in the same IDLE cycle on the same channel: treated as already complete, with no WAIT.
- Width rule: counter is 16 bits and saturates. timeout_err clears only on reset.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds output ports:
  - perf_data_stall_cyc (32): counts cycles with data_stall & ~long_stall.
  - perf_long_stall_cyc (32): counts cycles with long_stall.
  - perf_flush_cnt (32): counts cycles with bubble[ID]=1 outside reset.
- The counters are wrapping, reset to 0 asynchronously, and free-running.
- When undefined, these ports and registers do not exist. Functional behaviour is identical either way.

Decomposition:
- Package hazard_pkg holds:
  - stage index constants STG_IF=0 .. STG_WB=4, and NUM_STAGES=5.
  - tracker state encoding IDLE=2'd0, WAIT=2'd1, ABORT=2'd2.
  - default channel ids CH_CACHE, CH_BUS, CH_ACC.
- Sub-module long_op_tracker contains the FSM, pending mask, counter and timeout_err, and outputs long_stall.
- The top level holds the combinational hazard logic and output muxing.

Test Plan:
- Load-use:
  - Stimulus: ex_mem_read=1, ex_rd=5; ID with rs1=5 used.
  - Required: stall=5'b00011, bubble=5'b00100.
  - With rs1=0 instead: stall=0, bubble=0.
- Branch after ALU:
  - Stimulus: id_branch=1, rs2=7 used; ex_reg_write=1, ex_rd=7 for one cycle, then the hazard clears.
  - Required: a single stall cycle, then id_redirect=1 gives bubble=5'b00010.
- Two-channel miss:
  - Stimulus: long_req=3'b011; long_done[0] 3 cycles later, long_done[1] 6 cycles later.
  - Required: stall=5'b11111 for exactly 7 cycles starting in the request cycle. pending goes 011 → 010 → 000. long_busy then returns to 0.
- Same-cycle done:
  - Stimulus: long_req=3'b100 together with long_done=3'b100.
  - Required: stall=5'b11111 is not asserted (request already complete) and long_busy stays 0.
- Timeout:
  - Stimulus: TIMEOUT_CYC=4, long_req=3'b001, no done.
  - Required: WAIT for 4 cycles, then ABORT for 1 cycle; timeout_err=1 and stays 1; pending=0; IDLE afterwards.
- Reset mid-WAIT:
  - Stimulus: drop rst_n asynchronously.
  - Required: stall=0 and bubble=5'b11111 immediately, pending=0, long_busy=0; perf counters = 0 when HAZARD_PERF_CNT_EN is defined.
